// File: rtl/vga_pkg.sv
// VGA 640x480 timing constants and shared SRAM arbiter types.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Two 8-bit grey pixels per 16-bit SRAM word
    localparam int FRAME_WORDS = H_VISIBLE * V_VISIBLE / 2;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } sram_state_t;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO holding packed {address, word} entries for the loader.
module word_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         i_clk_25M,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                     (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign o_dout  = mem[rd_ptr[PW-1:0]];
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk_25M) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= i_din;
    end

endmodule

// File: rtl/vga_sram_arbiter.sv
// Single-port SRAM arbiter: VGA reads always win, RS232 pixel
// pairs are packed into words and written through a small FIFO.
module vga_sram_arbiter
    import vga_pkg::*;
#(
    parameter int AW          = 20,
    parameter int FRAME_WORDS = vga_pkg::FRAME_WORDS,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic          i_clk_25M,
    input  logic          i_rst,
    input  logic          i_frame_start,
    input  logic [7:0]    i_wr_data,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic          i_rd_req,
    input  logic [AW-1:0] i_rd_addr,
    output logic [15:0]   o_rd_data,
    output logic          o_rd_valid,
    output logic          o_frame_done,
    output logic [AW-1:0] o_sram_addr,
    output logic [15:0]   o_sram_dq_out,
    output logic          o_sram_dq_oe,
    input  logic [15:0]   i_sram_dq_in,
    output logic          o_sram_ce_n,
    output logic          o_sram_oe_n,
    output logic          o_sram_we_n
);

    localparam int FW = AW + 16;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_WORDS - 1);

    sram_state_t   state;
    sram_state_t   state_nxt;
    logic          hold_valid;
    logic [7:0]    hold_byte;
    logic [AW-1:0] wr_addr;
    logic          accept;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_dout;

    assign o_wr_ready = !(fifo_full && hold_valid);
    assign accept     = i_wr_valid && o_wr_ready;
    assign push       = accept && hold_valid && !i_frame_start;
    assign pop        = (state_nxt == WRITE);

    word_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk_25M (i_clk_25M),
        .i_rst     (i_rst),
        .i_flush   (i_frame_start),
        .i_push    (push),
        .i_pop     (pop),
        .i_din     ({wr_addr, i_wr_data, hold_byte}),
        .o_dout    (fifo_dout),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );

    // A byte arriving with frame_start becomes the low byte of word 0
    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) begin
            hold_valid <= 1'b0;
            hold_byte  <= '0;
            wr_addr    <= '0;
        end else if (i_frame_start) begin
            hold_valid <= accept;
            if (accept) hold_byte <= i_wr_data;
            wr_addr <= '0;
        end else if (accept) begin
            if (hold_valid) begin
                hold_valid <= 1'b0;
                wr_addr    <= (wr_addr == LAST_ADDR) ? '0
                                                     : wr_addr + 1'b1;
            end else begin
                hold_valid <= 1'b1;
                hold_byte  <= i_wr_data;
            end
        end
    end

    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        if (i_rd_req)
            state_nxt = READ;
        else if (!fifo_empty && !i_frame_start)
            state_nxt = WRITE;
    end

    always_comb begin
        o_sram_ce_n  = 1'b1;
        o_sram_oe_n  = 1'b1;
        o_sram_we_n  = 1'b1;
        o_sram_dq_oe = 1'b0;
        o_frame_done = 1'b0;
        unique case (state)
            READ: begin
                o_sram_ce_n = 1'b0;
                o_sram_oe_n = 1'b0;
            end
            WRITE: begin
                o_sram_ce_n  = 1'b0;
                o_sram_we_n  = 1'b0;
                o_sram_dq_oe = 1'b1;
                o_frame_done = (o_sram_addr == LAST_ADDR);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk_25M or posedge i_rst) begin
        if (i_rst) begin
            o_rd_valid    <= 1'b0;
            o_rd_data     <= '0;
            o_sram_addr   <= '0;
            o_sram_dq_out <= '0;
        end else begin
            o_rd_valid <= (state == READ);
            if (state == READ) o_rd_data <= i_sram_dq_in;
            case (state_nxt)
                READ: o_sram_addr <= i_rd_addr;
                WRITE: begin
                    o_sram_addr   <= fifo_dout[FW-1:16];
                    o_sram_dq_out <= fifo_dout[15:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Randomized bench for vga_sram_arbiter against a byte-stream model;
// a second instance uses an 8-word frame to exercise address wrap.
module tb_vga_sram_arbiter;

    localparam int AW   = 20;
    localparam int FW_B = 8;

    typedef struct {
        int          k;
        logic [15:0] d;
    } exp_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic          a_ready, a_rd_valid, a_done, a_dq_oe;
    logic          a_ce_n, a_oe_n, a_we_n;
    logic [15:0]   a_rd_data, a_dq_out, a_dq_in;
    logic [AW-1:0] a_addr;

    logic          b_ready, b_rd_valid, b_done, b_dq_oe;
    logic          b_ce_n, b_oe_n, b_we_n;
    logic [15:0]   b_rd_data, b_dq_out, b_dq_in;
    logic [AW-1:0] b_addr;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    wr_t  wa_q[$];
    wr_t  wb_q[$];
    int   fd_cnt = 0;
    int   strobe_err = 0;
    bit   m_have;
    logic [7:0] m_lo;
    int   m_k;

    function automatic logic [15:0] sram_word(logic [AW-1:0] a);
        return (a == 20'h00010) ? 16'hBEEF : (a[15:0] ^ 16'hA5C3);
    endfunction

    assign a_dq_in = sram_word(a_addr);
    assign b_dq_in = sram_word(b_addr);

    always #5 clk = ~clk;

    vga_sram_arbiter #(.AW(AW)) dut (
        .i_clk_25M     (clk),
        .i_rst         (rst),
        .i_frame_start (frame_start),
        .i_wr_data     (wr_data),
        .i_wr_valid    (wr_valid),
        .o_wr_ready    (a_ready),
        .i_rd_req      (rd_req),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (a_rd_data),
        .o_rd_valid    (a_rd_valid),
        .o_frame_done  (a_done),
        .o_sram_addr   (a_addr),
        .o_sram_dq_out (a_dq_out),
        .o_sram_dq_oe  (a_dq_oe),
        .i_sram_dq_in  (a_dq_in),
        .o_sram_ce_n   (a_ce_n),
        .o_sram_oe_n   (a_oe_n),
        .o_sram_we_n   (a_we_n)
    );

    vga_sram_arbiter #(.AW(AW), .FRAME_WORDS(FW_B)) dut_w (
        .i_clk_25M     (clk),
        .i_rst         (rst),
        .i_frame_start (frame_start),
        .i_wr_data     (wr_data),
        .i_wr_valid    (wr_valid),
        .o_wr_ready    (b_ready),
        .i_rd_req      (rd_req),
        .i_rd_addr     (rd_addr),
        .o_rd_data     (b_rd_data),
        .o_rd_valid    (b_rd_valid),
        .o_frame_done  (b_done),
        .o_sram_addr   (b_addr),
        .o_sram_dq_out (b_dq_out),
        .o_sram_dq_oe  (b_dq_oe),
        .i_sram_dq_in  (b_dq_in),
        .o_sram_ce_n   (b_ce_n),
        .o_sram_oe_n   (b_oe_n),
        .o_sram_we_n   (b_we_n)
    );

    // Byte-stream model: pairs of accepted bytes become numbered words
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_have = 1'b0;
            m_lo   = '0;
            m_k    = 0;
            exp_q.delete();
            wa_q.delete();
            wb_q.delete();
        end else if (frame_start) begin
            m_have = wr_valid && a_ready;
            m_lo   = wr_data;
            m_k    = 0;
        end else if (wr_valid && a_ready) begin
            if (m_have) begin
                exp_q.push_back('{k: m_k, d: {wr_data, m_lo}});
                m_k++;
                m_have = 1'b0;
            end else begin
                m_have = 1'b1;
                m_lo   = wr_data;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (a_we_n === 1'b0) wa_q.push_back('{a: a_addr, d: a_dq_out});
            if (b_we_n === 1'b0) wb_q.push_back('{a: b_addr, d: b_dq_out});
            if (b_done === 1'b1) fd_cnt++;
            if (a_we_n === 1'b0 &&
                (a_dq_oe !== 1'b1 || a_ce_n !== 1'b0 || a_oe_n !== 1'b1))
                strobe_err++;
            if (a_oe_n === 1'b0 &&
                (a_ce_n !== 1'b0 || a_we_n !== 1'b1 || a_dq_oe !== 1'b0))
                strobe_err++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        wr_valid    = 1'b0;
        rd_req      = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        exp_q.delete();
        wa_q.delete();
        wb_q.delete();
        fd_cnt = 0;
    endtask

    task automatic wait_writes(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (wa_q.size() == exp_q.size() &&
                wb_q.size() == exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        bit found;
        int busy;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({a_ce_n, a_oe_n, a_we_n, a_dq_oe} !== 4'b1110) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=1110",
                     {a_ce_n, a_oe_n, a_we_n, a_dq_oe});
        end
        checks++;
        if ({a_ready, a_rd_valid, a_done} !== 3'b100 ||
            a_rd_data !== 16'h0 || a_addr !== '0 || a_dq_out !== 16'h0) begin
            failures++;
            $display("FAIL reset_values got=%b/%h/%h/%h exp=100/0/0/0",
                     {a_ready, a_rd_valid, a_done}, a_rd_data, a_addr,
                     a_dq_out);
        end
        rst = 1'b0;
        tick();
        start_frame();
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        tick();
        wr_data = 8'hC3;
        tick();
        wr_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (a_we_n === 1'b0) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reset_write_seen got=0 exp=1");
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({a_we_n, a_ce_n, a_dq_oe} !== 3'b110) begin
            failures++;
            $display("FAIL reset_async got=%b exp=110",
                     {a_we_n, a_ce_n, a_dq_oe});
        end
        tick();
        rst = 1'b0;
        busy = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (a_ce_n !== 1'b1) busy++;
        end
        checks++;
        if (a_ready !== 1'b1 || busy != 0) begin
            failures++;
            $display("FAIL reset_after got=ready%b busy%0d exp=ready1 busy0",
                     a_ready, busy);
        end
    endtask

    task automatic test_read();
        rd_req  = 1'b1;
        rd_addr = 20'h00010;
        tick();
        rd_req = 1'b0;
        checks++;
        if (a_addr !== 20'h00010 || a_oe_n !== 1'b0 || a_rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_issue got=%h/%b/%b exp=00010/0/0",
                     a_addr, a_oe_n, a_rd_valid);
        end
        tick();
        checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 16'hBEEF) begin
            failures++;
            $display("FAIL read_data got=%b/%h exp=1/beef",
                     a_rd_valid, a_rd_data);
        end
    endtask

    task automatic test_write_pack();
        bit ok;
        start_frame();
        wr_valid = 1'b1;
        wr_data  = 8'h12;
        tick();
        wr_data = 8'h34;
        tick();
        wr_valid = 1'b0;
        wait_writes(ok);
        checks++;
        if (!ok || wa_q.size() != 1) begin
            failures++;
            $display("FAIL pack_count got=%0d exp=1", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0].a !== '0 || wa_q[0].d !== 16'h3412) begin
                failures++;
                $display("FAIL pack_word got=%h:%h exp=00000:3412",
                         wa_q[0].a, wa_q[0].d);
            end
        end
    endtask

    task automatic test_contention();
        logic [7:0]  bytes [64];
        logic [15:0] d1, d2;
        bit          v1, v2, ok;
        int          i;
        foreach (bytes[j]) bytes[j] = 8'($urandom);
        start_frame();
        i  = 0;
        v1 = 1'b0;
        v2 = 1'b0;
        d1 = '0;
        d2 = '0;
        for (int c = 0; c < 144; c++) begin
            checks++;
            if (a_rd_valid !== v2 || (v2 && a_rd_data !== d2)) begin
                failures++;
                $display("FAIL contention_read c=%0d got=%b/%h exp=%b/%h",
                         c, a_rd_valid, a_rd_data, v2, d2);
            end
            v2 = v1;
            d2 = d1;
            rd_req  = (c % 2 == 0) && (c < 140);
            rd_addr = AW'($urandom);
            v1 = rd_req;
            d1 = sram_word(rd_addr);
            wr_valid = (i < 64);
            if (i < 64) wr_data = bytes[i];
            if (wr_valid && a_ready) i++;
            tick();
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        wait_writes(ok);
        checks++;
        if (!ok || i != 64 || wa_q.size() != 32) begin
            failures++;
            $display("FAIL contention_count got=%0d/%0d exp=64/32",
                     i, wa_q.size());
        end
        for (int j = 0; j < wa_q.size() && j < exp_q.size(); j++) begin
            checks++;
            if (wa_q[j].a !== AW'(j) ||
                wa_q[j].d !== {bytes[2*j+1], bytes[2*j]}) begin
                failures++;
                $display("FAIL contention_word%0d got=%h:%h exp=%h:%h", j,
                         wa_q[j].a, wa_q[j].d, AW'(j),
                         {bytes[2*j+1], bytes[2*j]});
            end
        end
    endtask

    task automatic test_starvation();
        int acc;
        bit ok;
        start_frame();
        acc    = 0;
        rd_req = 1'b1;
        for (int c = 0; c < 30; c++) begin
            rd_addr  = AW'($urandom);
            wr_valid = 1'b1;
            wr_data  = 8'($urandom);
            if (a_ready) acc++;
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (acc != 9 || a_ready !== 1'b0 || wa_q.size() != 0) begin
            failures++;
            $display("FAIL starve_backpressure got=%0d/%b/%0d exp=9/0/0",
                     acc, a_ready, wa_q.size());
        end
        rd_req = 1'b0;
        wait_writes(ok);
        checks++;
        if (!ok || wa_q.size() != 4 || a_ready !== 1'b1) begin
            failures++;
            $display("FAIL starve_drain got=%0d/%b exp=4/1",
                     wa_q.size(), a_ready);
        end
        wr_valid = 1'b1;
        wr_data  = 8'($urandom);
        tick();
        wr_valid = 1'b0;
        wait_writes(ok);
        checks++;
        if (!ok || wa_q.size() != 5) begin
            failures++;
            $display("FAIL starve_tail got=%0d exp=5", wa_q.size());
        end
        for (int j = 0; j < wa_q.size() && j < exp_q.size(); j++) begin
            checks++;
            if (wa_q[j].a !== AW'(exp_q[j].k) || wa_q[j].d !== exp_q[j].d) begin
                failures++;
                $display("FAIL starve_word%0d got=%h:%h exp=%h:%h", j,
                         wa_q[j].a, wa_q[j].d, exp_q[j].k, exp_q[j].d);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        start_frame();
        for (int n = 0; n < 18;) begin
            wr_valid = 1'b1;
            wr_data  = 8'($urandom);
            if (b_ready) n++;
            tick();
        end
        wr_valid = 1'b0;
        wait_writes(ok);
        checks++;
        if (!ok || wb_q.size() != 9 || fd_cnt != 1) begin
            failures++;
            $display("FAIL wrap_count got=%0d/%0d exp=9/1",
                     wb_q.size(), fd_cnt);
        end
        for (int j = 0; j < wb_q.size() && j < exp_q.size(); j++) begin
            checks++;
            if (wb_q[j].a !== AW'(j % FW_B) || wb_q[j].d !== exp_q[j].d) begin
                failures++;
                $display("FAIL wrap_word%0d got=%h:%h exp=%h:%h", j,
                         wb_q[j].a, wb_q[j].d, j % FW_B, exp_q[j].d);
            end
        end
        checks++;
        if (wa_q.size() != 9 || wa_q[wa_q.size()-1].a !== AW'(8)) begin
            failures++;
            $display("FAIL wrap_nowrap_count got=%0d exp=9", wa_q.size());
        end
    endtask

    task automatic test_frame_start_mid();
        bit ok;
        start_frame();
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        tick();
        frame_start = 1'b1;
        wr_data     = 8'h01;
        tick();
        frame_start = 1'b0;
        wr_data     = 8'h02;
        tick();
        wr_valid = 1'b0;
        wait_writes(ok);
        checks++;
        if (!ok || wa_q.size() != 1) begin
            failures++;
            $display("FAIL fstart_count got=%0d exp=1", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0].a !== '0 || wa_q[0].d !== 16'h0201) begin
                failures++;
                $display("FAIL fstart_word got=%h:%h exp=00000:0201",
                         wa_q[0].a, wa_q[0].d);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d1, d2;
        bit          v1, v2, ok;
        start_frame();
        v1 = 1'b0;
        v2 = 1'b0;
        d1 = '0;
        d2 = '0;
        for (int c = 0; c < 304; c++) begin
            checks++;
            if (a_rd_valid !== v2 || (v2 && a_rd_data !== d2)) begin
                failures++;
                $display("FAIL b2b_read c=%0d got=%b/%h exp=%b/%h",
                         c, a_rd_valid, a_rd_data, v2, d2);
            end
            v2 = v1;
            d2 = d1;
            rd_req  = (c < 300) && ($urandom_range(0, 2) == 0);
            rd_addr = AW'($urandom);
            v1 = rd_req;
            d1 = sram_word(rd_addr);
            wr_valid = (c < 300) && ($urandom_range(0, 3) != 0);
            wr_data  = 8'($urandom);
            tick();
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        wait_writes(ok);
        checks++;
        if (!ok || wa_q.size() != exp_q.size() || exp_q.size() < 50) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=%0d",
                     wa_q.size(), exp_q.size());
        end
        for (int j = 0; j < wa_q.size() && j < exp_q.size(); j++) begin
            checks++;
            if (wa_q[j].a !== AW'(exp_q[j].k) || wa_q[j].d !== exp_q[j].d) begin
                failures++;
                $display("FAIL b2b_word%0d got=%h:%h exp=%h:%h", j,
                         wa_q[j].a, wa_q[j].d, exp_q[j].k, exp_q[j].d);
            end
        end
    endtask

    task automatic test_strobes();
        checks++;
        if (strobe_err != 0) begin
            failures++;
            $display("FAIL strobes got=%0d exp=0", strobe_err);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_pack();
        test_contention();
        test_starvation();
        test_wrap();
        test_frame_start_mid();
        test_back_to_back();
        test_strobes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
